// File: rtl/spi_slave.sv
// -----------------------------------------------------------------------------
// spi_slave
//
// Byte-oriented SPI slave. It runs entirely in the sys_clk domain and
// oversamples the master's cs/sclk/mosi. The SPI mode is set by CPOL (sclk
// idle level) and CPHA (0: sample on the leading edge, 1: sample on the
// trailing edge). Every sclk half-period must last at least 4 sys_clk cycles.
//
// Ports
//   sys_clk   in   system clock; all logic runs on its rising edge
//   sys_rst_n in   asynchronous active-low reset
//   cs        in   chip select from the master, active low, asynchronous
//   sclk      in   SPI clock from the master, asynchronous
//   mosi      in   serial data from the master, MSB first
//   miso      out  serial data to the master, MSB first; 0 while not driven
//   miso_oe   out  miso drive enable, high only during a selected transfer
//   data_tx   in   next byte to transmit, taken while tx_ack is high
//   tx_ack    out  one-cycle pulse: data_tx copied into the transmit shifter
//   data_rx   out  last complete received byte, held until the next one
//   rx_valid  out  one-cycle pulse: data_rx has just been updated
//   busy      out  high whenever the FSM is not idle
// -----------------------------------------------------------------------------
module spi_slave #(
  parameter logic CPOL = 1'b1,
  parameter logic CPHA = 1'b1
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       cs,
  input  logic       sclk,
  input  logic       mosi,
  output logic       miso,
  output logic       miso_oe,
  input  logic [7:0] data_tx,
  output logic       tx_ack,
  output logic [7:0] data_rx,
  output logic       rx_valid,
  output logic       busy
);

  typedef enum logic [1:0] {
    S0_IDLE  = 2'd0,
    S1_LOAD  = 2'd1,
    S2_SHIFT = 2'd2,
    S3_DONE  = 2'd3
  } state_t;

  state_t state;
  state_t next_state;

  // ---------------------------------------------------------------------------
  // Input synchronisers. Bit 0 is the metastability stage, bit 1 the
  // synchronised value, bit 2 the previous synchronised value used to detect
  // edges.
  // ---------------------------------------------------------------------------
  logic [2:0] cs_pipe;
  logic [2:0] sclk_pipe;
  logic [2:0] mosi_pipe;

  // NOTE: the synchronisers reset to the idle levels of the bus (cs high, sclk
  // at CPOL) rather than to 0, so releasing reset cannot fabricate an edge.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cs_pipe   <= 3'b111;
      sclk_pipe <= {3{CPOL}};
      mosi_pipe <= 3'b000;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge value of its neighbour; blocking here would
      // collapse the synchroniser chain into a single stage.
      cs_pipe   <= {cs_pipe[1:0], cs};
      sclk_pipe <= {sclk_pipe[1:0], sclk};
      mosi_pipe <= {mosi_pipe[1:0], mosi};
    end
  end

  logic cs_s;
  logic cs_fall;
  logic cs_rise;
  logic mosi_s;
  logic sclk_lead;
  logic sclk_trail;
  logic sample_edge;
  logic shift_edge;

  assign cs_s    = cs_pipe[1];
  assign cs_fall = cs_pipe[2] & ~cs_pipe[1];
  assign cs_rise = ~cs_pipe[2] & cs_pipe[1];
  assign mosi_s  = mosi_pipe[1];

  // Leading edge leaves the idle level, trailing edge returns to it.
  assign sclk_lead  = (sclk_pipe[2] == CPOL) && (sclk_pipe[1] != CPOL);
  assign sclk_trail = (sclk_pipe[2] != CPOL) && (sclk_pipe[1] == CPOL);

  assign sample_edge = CPHA ? sclk_trail : sclk_lead;
  assign shift_edge  = CPHA ? sclk_lead  : sclk_trail;

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  logic [7:0] tx_shift;
  logic [7:0] rx_shift;
  logic [2:0] bit_cnt;
  // Set by the first sample edge after a load. A shift edge seen before any
  // sample edge belongs to the load itself (the MSB is already on miso) and
  // must not advance the transmit shifter. With CPHA=1 this skips the first
  // leading edge of every byte; with CPHA=0 it absorbs the trailing edge that
  // follows the 8th sample edge, which arrives after the S3_DONE reload.
  logic       shift_armed;

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state <= S0_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next state and Moore outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable written here gets a default first; any path that
    // skipped an assignment would otherwise infer a latch.
    next_state = state;
    tx_ack     = 1'b0;

    case (state)
      S0_IDLE: begin
        if (cs_fall) next_state = S1_LOAD;
      end
      S1_LOAD: begin
        tx_ack     = 1'b1;
        next_state = S2_SHIFT;
      end
      S2_SHIFT: begin
        if (sample_edge && (bit_cnt == 3'd7)) next_state = S3_DONE;
      end
      S3_DONE: begin
        tx_ack     = 1'b1;
        next_state = S2_SHIFT;
      end
      default: next_state = S0_IDLE;
    endcase

    // Deselect aborts from any state and beats a simultaneous 8th sample
    // edge, so a byte cut short by cs never reaches S3_DONE.
    if (cs_rise) next_state = S0_IDLE;
  end

  // ---------------------------------------------------------------------------
  // Shift registers, bit counter and receive outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      tx_shift    <= 8'h00;
      rx_shift    <= 8'h00;
      bit_cnt     <= 3'd0;
      shift_armed <= 1'b0;
      data_rx     <= 8'h00;
      rx_valid    <= 1'b0;
    end else begin
      rx_valid <= 1'b0;

      case (state)
        S1_LOAD: begin
          tx_shift    <= data_tx;
          rx_shift    <= 8'h00;
          bit_cnt     <= 3'd0;
          shift_armed <= 1'b0;
        end
        S2_SHIFT: begin
          if (sample_edge) begin
            rx_shift    <= {rx_shift[6:0], mosi_s};
            bit_cnt     <= bit_cnt + 3'd1;
            shift_armed <= 1'b1;
          end else if (shift_edge && shift_armed) begin
            tx_shift <= {tx_shift[6:0], 1'b0};
          end
        end
        S3_DONE: begin
          // rx_valid is registered here so it rises together with the new
          // data_rx value.
          data_rx     <= rx_shift;
          rx_valid    <= 1'b1;
          tx_shift    <= data_tx;
          bit_cnt     <= 3'd0;
          shift_armed <= 1'b0;
        end
        default: begin
          // Idle: sclk activity is ignored and all registers hold.
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Output drive
  // ---------------------------------------------------------------------------
  assign busy    = (state != S0_IDLE);
  assign miso_oe = busy & ~cs_s;
  assign miso    = miso_oe & tx_shift[7];

endmodule

// File: tb/tb_spi_slave.sv
// -----------------------------------------------------------------------------
// tb_spi_slave
//
// Directed bench for spi_slave. Instance u_dut_a runs the default mode
// (CPOL=1, CPHA=1); instance u_dut_b runs CPOL=0, CPHA=0. A single bus master
// model drives whichever instance is selected by 'sel'; the other one sees an
// idle bus. Expected values are written out by hand at every step.
// -----------------------------------------------------------------------------
module tb_spi_slave;

  localparam int HALF = 8;  // sclk half-period in sys_clk cycles

  logic       sys_clk;
  logic       sys_rst_n;
  logic       sel;
  logic       m_cs;
  logic       m_sclk;
  logic       m_mosi;
  logic [7:0] data_tx;

  logic       cs_a, sclk_a, miso_a, miso_oe_a, tx_ack_a, rx_valid_a, busy_a;
  logic [7:0] data_rx_a;
  logic       cs_b, sclk_b, miso_b, miso_oe_b, tx_ack_b, rx_valid_b, busy_b;
  logic [7:0] data_rx_b;
  logic       miso_sel;

  assign cs_a     = sel ? 1'b1 : m_cs;
  assign sclk_a   = sel ? 1'b1 : m_sclk;
  assign cs_b     = sel ? m_cs : 1'b1;
  assign sclk_b   = sel ? m_sclk : 1'b0;
  assign miso_sel = sel ? miso_b : miso_a;

  spi_slave #(.CPOL(1'b1), .CPHA(1'b1)) u_dut_a (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .cs       (cs_a),
    .sclk     (sclk_a),
    .mosi     (m_mosi),
    .miso     (miso_a),
    .miso_oe  (miso_oe_a),
    .data_tx  (data_tx),
    .tx_ack   (tx_ack_a),
    .data_rx  (data_rx_a),
    .rx_valid (rx_valid_a),
    .busy     (busy_a)
  );

  spi_slave #(.CPOL(1'b0), .CPHA(1'b0)) u_dut_b (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .cs       (cs_b),
    .sclk     (sclk_b),
    .mosi     (m_mosi),
    .miso     (miso_b),
    .miso_oe  (miso_oe_b),
    .data_tx  (data_tx),
    .tx_ack   (tx_ack_b),
    .data_rx  (data_rx_b),
    .rx_valid (rx_valid_b),
    .busy     (busy_b)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Event monitors, sampled on the falling edge where outputs are stable.
  int         rx_cnt_a   = 0;
  int         rx_cnt_b   = 0;
  int         ack_cnt_a  = 0;
  int         busy_cyc_a = 0;
  logic [7:0] rx_log_a [0:15];

  always @(negedge sys_clk) begin
    if (rx_valid_a === 1'b1) begin
      rx_log_a[rx_cnt_a % 16] = data_rx_a;
      rx_cnt_a = rx_cnt_a + 1;
    end
    if (rx_valid_b === 1'b1) rx_cnt_b = rx_cnt_b + 1;
    if (tx_ack_a === 1'b1)   ack_cnt_a = ack_cnt_a + 1;
    if (busy_a === 1'b1)     busy_cyc_a = busy_cyc_a + 1;
  end

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  // Master clocks out n bits of b (MSB first) and returns what it sampled
  // on miso at each of its sample points; unsent bit positions read 0.
  task automatic master_bits(input logic [7:0] b, input int n,
                             input logic cpol, input logic cpha,
                             output logic [7:0] got);
    got = 8'h00;
    for (int i = 7; i > 7 - n; i--) begin
      if (!cpha) begin
        m_mosi = b[i];
        wait_cycles(HALF);
        got[i] = miso_sel;
        m_sclk = ~cpol;
        wait_cycles(HALF);
        m_sclk = cpol;
      end else begin
        m_sclk = ~cpol;
        m_mosi = b[i];
        wait_cycles(HALF);
        got[i] = miso_sel;
        m_sclk = cpol;
        wait_cycles(HALF);
      end
    end
  endtask

  task automatic cs_low();
    m_cs = 1'b0;
    wait_cycles(8);
  endtask

  task automatic cs_high();
    wait_cycles(HALF);
    m_cs = 1'b1;
    wait_cycles(8);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] got;
    logic [7:0] got2;
    int         rx_base;
    int         ack_base;
    int         busy_base;

    sys_rst_n = 1'b0;
    sel       = 1'b0;
    m_cs      = 1'b1;
    m_sclk    = 1'b1;
    m_mosi    = 1'b0;
    data_tx   = 8'h00;
    wait_cycles(3);

    // Reset state
    check("rst_busy",     busy_a,     1'b0);
    check("rst_miso",     miso_a,     1'b0);
    check("rst_miso_oe",  miso_oe_a,  1'b0);
    check("rst_tx_ack",   tx_ack_a,   1'b0);
    check("rst_rx_valid", rx_valid_a, 1'b0);
    check("rst_data_rx",  data_rx_a,  8'h00);

    sys_rst_n = 1'b1;
    wait_cycles(4);

    // Mode 3: master sends 0xA5, slave returns 0x3C
    data_tx  = 8'h3C;
    rx_base  = rx_cnt_a;
    ack_base = ack_cnt_a;
    cs_low();
    check("m3_busy_sel",    busy_a,               1'b1);
    check("m3_oe_sel",      miso_oe_a,            1'b1);
    check("m3_tx_ack_load", ack_cnt_a - ack_base, 32'd1);
    master_bits(8'hA5, 8, 1'b1, 1'b1, got);
    cs_high();
    check("m3_miso_byte", got,                 8'h3C);
    check("m3_data_rx",   data_rx_a,           8'hA5);
    check("m3_rx_pulses", rx_cnt_a - rx_base,  32'd1);
    check("m3_idle_busy", busy_a,              1'b0);
    check("m3_idle_oe",   miso_oe_a,           1'b0);
    check("m3_idle_miso", miso_a,              1'b0);

    // Mode 3: two back-to-back bytes under one cs
    data_tx  = 8'h81;
    rx_base  = rx_cnt_a;
    ack_base = ack_cnt_a;
    cs_low();
    data_tx = 8'h7E;
    master_bits(8'h12, 8, 1'b1, 1'b1, got);
    master_bits(8'h34, 8, 1'b1, 1'b1, got2);
    cs_high();
    check("b2b_miso_byte0", got,                   8'h81);
    check("b2b_miso_byte1", got2,                  8'h7E);
    check("b2b_rx_pulses",  rx_cnt_a - rx_base,    32'd2);
    check("b2b_rx_first",   rx_log_a[rx_base % 16],       8'h12);
    check("b2b_rx_second",  rx_log_a[(rx_base + 1) % 16], 8'h34);
    check("b2b_tx_acks",    ack_cnt_a - ack_base,  32'd3);
    check("b2b_data_rx",    data_rx_a,             8'h34);

    // Abort after 5 bits: byte discarded, outputs idle within 4 cycles
    data_tx = 8'h00;
    rx_base = rx_cnt_a;
    cs_low();
    master_bits(8'hFF, 5, 1'b1, 1'b1, got);
    m_cs = 1'b1;
    wait_cycles(4);
    check("abort_busy",    busy_a,             1'b0);
    check("abort_oe",      miso_oe_a,          1'b0);
    check("abort_rx",      rx_cnt_a - rx_base, 32'd0);
    check("abort_data_rx", data_rx_a,          8'h34);

    // sclk toggling with cs high is ignored
    rx_base   = rx_cnt_a;
    ack_base  = ack_cnt_a;
    busy_base = busy_cyc_a;
    for (int i = 0; i < 12; i++) begin
      m_sclk = ~m_sclk;
      m_mosi = i[0];
      wait_cycles(HALF);
    end
    check("idle_sclk_rx",   rx_cnt_a - rx_base,      32'd0);
    check("idle_sclk_ack",  ack_cnt_a - ack_base,    32'd0);
    check("idle_sclk_busy", busy_cyc_a - busy_base,  32'd0);

    // Reset pulsed mid-byte, then a clean 0x55 transfer
    data_tx = 8'h99;
    cs_low();
    master_bits(8'hAA, 4, 1'b1, 1'b1, got);
    sys_rst_n = 1'b0;
    #1;
    check("midrst_busy",     busy_a,     1'b0);
    check("midrst_miso",     miso_a,     1'b0);
    check("midrst_oe",       miso_oe_a,  1'b0);
    check("midrst_tx_ack",   tx_ack_a,   1'b0);
    check("midrst_rx_valid", rx_valid_a, 1'b0);
    check("midrst_data_rx",  data_rx_a,  8'h00);
    m_cs   = 1'b1;
    m_sclk = 1'b1;
    wait_cycles(2);
    sys_rst_n = 1'b1;
    wait_cycles(4);
    check("postrst_busy", busy_a, 1'b0);
    data_tx = 8'hC3;
    rx_base = rx_cnt_a;
    cs_low();
    master_bits(8'h55, 8, 1'b1, 1'b1, got);
    cs_high();
    check("postrst_data_rx", data_rx_a,          8'h55);
    check("postrst_rx",      rx_cnt_a - rx_base, 32'd1);
    check("postrst_miso",    got,                8'hC3);

    // Mode 0 on the second instance: master sends 0xF0, slave returns 0x0F
    m_sclk = 1'b0;
    sel    = 1'b1;
    wait_cycles(4);
    data_tx = 8'h0F;
    rx_base = rx_cnt_b;
    cs_low();
    check("m0_oe_sel",    miso_oe_b, 1'b1);
    check("m0_first_msb", miso_b,    1'b0);
    master_bits(8'hF0, 8, 1'b0, 1'b0, got);
    cs_high();
    check("m0_miso_byte", got,                8'h0F);
    check("m0_data_rx",   data_rx_b,          8'hF0);
    check("m0_rx_pulses", rx_cnt_b - rx_base, 32'd1);
    check("m0_idle_busy", busy_b,             1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 Parameter CPOL, default 1'b1, meaning sclk idle level.
REQ-002 Parameter CPHA, default 1'b1, meaning 0 = sample on leading edge, 1 = sample on trailing edge.
REQ-003 Port sys_clk  input  1  system clock, all logic on posedge; one clock domain only.
REQ-004 Port sys_rst_n  input  1  reset; asynchronous, active-low.
REQ-005 Port cs  input  1  chip select from master, active low, asynchronous to sys_clk.
REQ-006 Port sclk  input  1  SPI clock from master, asynchronous.
REQ-007 Port mosi  input  1  serial data from master, MSB first.
REQ-008 Port miso  output  1  serial data to master, MSB first.
REQ-009 Port miso_oe  output  1  miso drive enable; high only while cs is low after synchronisation.
REQ-010 Port data_tx  input  8  byte to transmit; sampled when tx_ack is high.
REQ-011 Port tx_ack  output  1  one-cycle pulse, data_tx latched into the transmit shift register.
REQ-012 Port data_rx  output  8  last complete received byte; holds until the next byte completes.
REQ-013 Port rx_valid  output  1  one-cycle pulse, data_rx updated.
REQ-014 Port busy  output  1  high in every state except S0_IDLE.

Function
REQ-015 cs, sclk and mosi SHALL each pass through a 2-FF synchroniser plus one history FF for edge detection.
REQ-016 Leading edge = synchronised sclk leaving CPOL; trailing edge = returning to CPOL.
REQ-017 Sample edge = leading if CPHA=0, trailing if CPHA=1; shift edge = the other edge.
REQ-018 The master SHALL hold each sclk half-period >= 4 sys_clk cycles; shorter half-periods are unsupported.
REQ-019 State machine states: S0_IDLE, S1_LOAD, S2_SHIFT, S3_DONE.
REQ-020 S0_IDLE -> S1_LOAD on a synchronised cs falling edge.
REQ-021 S1_LOAD lasts 1 cycle: latch data_tx, pulse tx_ack, clear bit_cnt and the receive shift register, then go to S2_SHIFT.
REQ-022 In S2_SHIFT, each sample edge SHALL shift the synchronised mosi into the receive register LSB and increment bit_cnt (3 bits).
REQ-023 On the sample edge with bit_cnt==7, the state SHALL go to S3_DONE.
REQ-024 S3_DONE lasts 1 cycle: data_rx <= the complete byte, pulse rx_valid, latch data_tx, pulse tx_ack, clear bit_cnt, then return to S2_SHIFT.
REQ-025 miso SHALL equal tx_shift[7] whenever miso_oe is high, and SHALL be 0 otherwise.
REQ-026 A shift edge SHALL shift tx_shift left by one, except when it is the first shift edge after a load (S1_LOAD or S3_DONE).
REQ-027 With CPHA=1, the skipped shift edge is the first leading edge of the byte.
REQ-028 With CPHA=0, the shift edge that follows the 8th sample edge is absorbed by the S3_DONE load; the new MSB is on miso before the next leading edge.
REQ-029 A synchronised cs rising edge in any state SHALL force S0_IDLE on the next cycle.
REQ-030 On that cs abort, a partial byte is discarded: no rx_valid, data_rx unchanged.
REQ-031 If cs rises in the same cycle as the 8th sample edge, the cs abort wins and no rx_valid is generated.
REQ-032 Sclk edges while in S0_IDLE are ignored.
REQ-033 Back-to-back bytes under one cs low SHALL be supported without limit.

Reset
REQ-034 Asynchronous reset SHALL clear the state (S0_IDLE), shift registers, bit_cnt, data_rx, rx_valid, tx_ack, busy, miso and miso_oe to 0.
REQ-035 Synchronisers SHALL reset to cs=1, sclk=CPOL, mosi=0, so that no false edge occurs after reset release.
REQ-036 Reset asserted mid-byte SHALL abort the transfer; the next cs falling edge starts a fresh byte.

Verification
REQ-037 CPOL=1, CPHA=1, sclk half-period 8 cycles, master sends 0xA5 while data_tx=0x3C -> miso bits 0,0,1,1,1,1,0,0; data_rx=0xA5; one rx_valid pulse.
REQ-038 Same mode, two bytes 0x12 then 0x34 under one cs, data_tx 0x81 then 0x7E -> rx_valid twice with data_rx 0x12 then 0x34; miso stream 0x81,0x7E; tx_ack three times (S1_LOAD plus two S3_DONE).
REQ-039 CPOL=0, CPHA=0, master sends 0xF0 with data_tx=0x0F -> MSB 0 on miso before the first rising edge; data_rx=0xF0.
REQ-040 cs raised after 5 bits -> no rx_valid, data_rx keeps its previous value, state S0_IDLE, miso_oe=0 within 4 cycles.
REQ-041 sys_rst_n pulsed low mid-byte -> all outputs 0; a following full 0x55 transfer yields data_rx=0x55.
REQ-042 Sclk toggling with cs high -> no rx_valid, no tx_ack, busy stays 0.
